// File: rtl/lapido_defs_pkg.sv
// Shared constants for the LAPIDO fetch stage: default PC width, bubble
// encoding and fetch FSM state encodings.
package lapido_defs_pkg;

    localparam int          DEF_PC_WIDTH = 16;
    localparam logic [31:0] NOP          = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_BOOT  = 2'd0,
        IF_RUN   = 2'd1,
        IF_STALL = 2'd2
    } if_state_e;

endpackage

// File: rtl/lapido_pc_reg.sv
// Program counter register: reset vector, hold, load (redirect) and
// modulo-2^PC_WIDTH increment. Load takes priority over increment.
module lapido_pc_reg #(
    parameter int                   PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [PC_WIDTH-1:0] load_val,
    input  logic                inc,
    output logic [PC_WIDTH-1:0] pc
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pc <= RESET_PC;
        else if (load)
            pc <= load_val;
        else if (inc)
            pc <= pc + PC_ONE;
    end

endmodule

// File: rtl/lapido_if_stage.sv
// Instruction fetch stage: PC, synchronous imem interface, skid buffer for
// decode stalls and the IF/ID pipeline register.
module lapido_if_stage
    import lapido_defs_pkg::*;
#(
    parameter int                   PC_WIDTH = DEF_PC_WIDTH,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_stall,
    input  logic                WB_IF_out_is_jump,
    input  logic                WB_IF_out_branch_taken,
    input  logic [PC_WIDTH-1:0] WB_IF_out_jump_addr,
    input  logic [PC_WIDTH-1:0] WB_IF_out_branch_addr,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [31:0]         imem_data,
    output logic [31:0]         IF_ID_instruction,
    output logic [PC_WIDTH-1:0] IF_ID_next_pc,
    output logic                IF_ID_valid
);

    localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

    logic                redirect;
    logic [PC_WIDTH-1:0] target;
    logic                advance;
    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] inflight_pc;
    logic                inflight_valid;
    logic [31:0]         skid_q;
    if_state_e           state, state_nxt;
    logic                load_ifid;
    logic                ifid_from_skid;
    logic                capture_skid;

    assign redirect = WB_IF_out_is_jump | WB_IF_out_branch_taken;
    assign target   = WB_IF_out_is_jump ? WB_IF_out_jump_addr : WB_IF_out_branch_addr;
    // Every state moves the fetch pointer forward on an unstalled, non-redirect edge
    assign advance  = !redirect && !if_stall;

    lapido_pc_reg #(
        .PC_WIDTH (PC_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (redirect),
        .load_val (target),
        .inc      (advance),
        .pc       (pc_q)
    );

    assign imem_addr = pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IF_BOOT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        load_ifid      = 1'b0;
        ifid_from_skid = 1'b0;
        capture_skid   = 1'b0;
        if (redirect) begin
            state_nxt = IF_RUN;
        end else begin
            case (state)
                IF_BOOT: begin
                    if (!if_stall)
                        state_nxt = IF_RUN;
                end
                IF_RUN: begin
                    if (if_stall) begin
                        // memory output moves on next edge; park the word we owe decode
                        state_nxt    = IF_STALL;
                        capture_skid = 1'b1;
                    end else begin
                        load_ifid = 1'b1;
                    end
                end
                IF_STALL: begin
                    if (!if_stall) begin
                        state_nxt      = IF_RUN;
                        load_ifid      = 1'b1;
                        ifid_from_skid = 1'b1;
                    end
                end
                default: state_nxt = IF_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_pc    <= '0;
            inflight_valid <= 1'b0;
        end else if (redirect) begin
            inflight_valid <= 1'b0;
        end else if (!if_stall) begin
            inflight_pc    <= pc_q;
            inflight_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            skid_q <= '0;
        else if (capture_skid)
            skid_q <= imem_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            IF_ID_instruction <= NOP;
            IF_ID_next_pc     <= '0;
            IF_ID_valid       <= 1'b0;
        end else if (redirect) begin
            IF_ID_instruction <= NOP;
            IF_ID_next_pc     <= '0;
            IF_ID_valid       <= 1'b0;
        end else if (load_ifid) begin
            IF_ID_instruction <= !inflight_valid ? NOP :
                                 (ifid_from_skid ? skid_q : imem_data);
            IF_ID_next_pc     <= inflight_pc + PC_ONE;
            IF_ID_valid       <= inflight_valid;
        end
    end

endmodule

// File: tb/tb_lapido_if_stage.sv
// Bench for lapido_if_stage: directed scenarios plus randomized stall/redirect
// traffic checked against an instruction-stream model.
module tb_lapido_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_stall = 1'b0;
    logic        is_jump = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] jump_addr = '0;
    logic [15:0] branch_addr = '0;
    logic [15:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] ifid_instr;
    logic [15:0] ifid_npc;
    logic        ifid_valid;

    logic        rst_w = 1'b0;
    logic [3:0]  imem_addr_w;
    logic [31:0] imem_data_w;
    logic [31:0] ifid_instr_w;
    logic [3:0]  ifid_npc_w;
    logic        ifid_valid_w;

    int n_checks = 0;
    int n_pass   = 0;

    // stream model: next PC to deliver, bubbles still owed, expected IF/ID
    logic [15:0] m_pc;
    int          m_pend;
    logic        m_valid;
    logic [31:0] m_instr;
    logic [15:0] m_npc;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [15:0] a);
        return 32'h1000_0000 + {16'h0, a};
    endfunction

    always @(posedge clk) imem_data   <= memf(imem_addr);
    always @(posedge clk) imem_data_w <= memf({12'h0, imem_addr_w});

    lapido_if_stage dut (
        .clk                    (clk),
        .rst                    (rst),
        .if_stall               (if_stall),
        .WB_IF_out_is_jump      (is_jump),
        .WB_IF_out_branch_taken (br_taken),
        .WB_IF_out_jump_addr    (jump_addr),
        .WB_IF_out_branch_addr  (branch_addr),
        .imem_addr              (imem_addr),
        .imem_data              (imem_data),
        .IF_ID_instruction      (ifid_instr),
        .IF_ID_next_pc          (ifid_npc),
        .IF_ID_valid            (ifid_valid)
    );

    lapido_if_stage #(.PC_WIDTH(4), .RESET_PC(4'd14)) dut_w (
        .clk                    (clk),
        .rst                    (rst_w),
        .if_stall               (1'b0),
        .WB_IF_out_is_jump      (1'b0),
        .WB_IF_out_branch_taken (1'b0),
        .WB_IF_out_jump_addr    (4'h0),
        .WB_IF_out_branch_addr  (4'h0),
        .imem_addr              (imem_addr_w),
        .imem_data              (imem_data_w),
        .IF_ID_instruction      (ifid_instr_w),
        .IF_ID_next_pc          (ifid_npc_w),
        .IF_ID_valid            (ifid_valid_w)
    );

    task automatic model_reset();
        m_pc = 16'h0; m_pend = 1; m_valid = 1'b0; m_instr = 32'h0; m_npc = 16'h0;
    endtask

    // drive one cycle of inputs, clock it, and advance the stream model
    task automatic step(input logic st, input logic j, input logic b,
                        input logic [15:0] ja, input logic [15:0] ba);
        if_stall = st; is_jump = j; br_taken = b; jump_addr = ja; branch_addr = ba;
        @(posedge clk); #1;
        if (j || b) begin
            m_valid = 1'b0; m_instr = 32'h0; m_npc = 16'h0;
            m_pc = j ? ja : ba; m_pend = 1;
        end else if (!st) begin
            if (m_pend > 0) begin
                m_pend--; m_valid = 1'b0; m_instr = 32'h0;
            end else begin
                m_valid = 1'b1; m_instr = memf(m_pc); m_npc = m_pc + 16'h1; m_pc = m_pc + 16'h1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (imem_addr !== 16'h0) $display("FAIL reset_addr: got %h want 0000", imem_addr); else n_pass++;
        n_checks++; if (ifid_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", ifid_valid); else n_pass++;
        n_checks++; if (ifid_instr !== 32'h0) $display("FAIL reset_instr: got %h want 00000000", ifid_instr); else n_pass++;
        n_checks++; if (ifid_npc !== 16'h0) $display("FAIL reset_npc: got %h want 0000", ifid_npc); else n_pass++;
        rst = 1'b1;
        model_reset();
    endtask

    task automatic test_sequential();
        step(0, 0, 0, 0, 0);
        n_checks++; if (ifid_valid !== 1'b0) $display("FAIL seq_edge1_valid: got %b want 0", ifid_valid); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0);
            n_checks++;
            if (ifid_valid !== 1'b1 || ifid_instr !== 32'h1000_0000 + i || ifid_npc !== 16'(i + 1))
                $display("FAIL seq_edge%0d: got v=%b i=%h npc=%h want v=1 i=%h npc=%h",
                         i + 2, ifid_valid, ifid_instr, ifid_npc, 32'h1000_0000 + i, 16'(i + 1));
            else n_pass++;
        end
    endtask

    task automatic test_jump();
        step(0, 1, 0, 16'h0040, 16'h0);
        n_checks++;
        if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_npc !== 16'h0)
            $display("FAIL jump_bubble1: got v=%b i=%h npc=%h want 0/0/0", ifid_valid, ifid_instr, ifid_npc);
        else n_pass++;
        step(0, 0, 0, 0, 0);
        n_checks++;
        if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0)
            $display("FAIL jump_bubble2: got v=%b i=%h want 0/0", ifid_valid, ifid_instr);
        else n_pass++;
        step(0, 0, 0, 0, 0);
        n_checks++;
        if (ifid_valid !== 1'b1 || ifid_instr !== 32'h1000_0040 || ifid_npc !== 16'h0041)
            $display("FAIL jump_target: got v=%b i=%h npc=%h want 1/10000040/0041", ifid_valid, ifid_instr, ifid_npc);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        logic saw30;
        saw30 = 1'b0;
        step(0, 1, 1, 16'h0020, 16'h0030);
        if (imem_addr === 16'h0030) saw30 = 1'b1;
        step(0, 0, 0, 0, 0);
        if (imem_addr === 16'h0030) saw30 = 1'b1;
        step(0, 0, 0, 0, 0);
        if (imem_addr === 16'h0030) saw30 = 1'b1;
        n_checks++;
        if (ifid_valid !== 1'b1 || ifid_instr !== 32'h1000_0020 || ifid_npc !== 16'h0021)
            $display("FAIL simul_target: got v=%b i=%h npc=%h want 1/10000020/0021", ifid_valid, ifid_instr, ifid_npc);
        else n_pass++;
        n_checks++; if (saw30 !== 1'b0) $display("FAIL simul_no_branch_addr: got saw30=%b want 0", saw30); else n_pass++;
        step(0, 0, 0, 0, 0);
        n_checks++;
        if (ifid_instr !== 32'h1000_0021) $display("FAIL simul_next: got %h want 10000021", ifid_instr); else n_pass++;
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0);
            n_checks++;
            if (ifid_valid !== 1'b1 || ifid_instr !== 32'h1000_0021 || ifid_npc !== 16'h0022)
                $display("FAIL stall_hold%0d: got v=%b i=%h npc=%h want 1/10000021/0022", i, ifid_valid, ifid_instr, ifid_npc);
            else n_pass++;
        end
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 0, 0, 0);
            n_checks++;
            if (ifid_valid !== 1'b1 || ifid_instr !== 32'h1000_0022 + i || ifid_npc !== 16'(16'h23 + i))
                $display("FAIL stall_resume%0d: got v=%b i=%h npc=%h want 1/%h/%h", i, ifid_valid, ifid_instr,
                         ifid_npc, 32'h1000_0022 + i, 16'(16'h23 + i));
            else n_pass++;
        end
    endtask

    task automatic test_redirect_stall();
        step(1, 0, 1, 16'h0, 16'h0010);
        n_checks++; if (ifid_valid !== 1'b0) $display("FAIL rs_bubble1: got v=%b want 0", ifid_valid); else n_pass++;
        step(0, 0, 0, 0, 0);
        n_checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) $display("FAIL rs_bubble2: got v=%b i=%h want 0/0", ifid_valid, ifid_instr); else n_pass++;
        step(0, 0, 0, 0, 0);
        n_checks++;
        if (ifid_valid !== 1'b1 || ifid_instr !== 32'h1000_0010 || ifid_npc !== 16'h0011)
            $display("FAIL rs_target: got v=%b i=%h npc=%h want 1/10000010/0011", ifid_valid, ifid_instr, ifid_npc);
        else n_pass++;
    endtask

    task automatic test_random();
        logic st, j, b;
        logic [15:0] ja, ba;
        for (int n = 0; n < 300; n++) begin
            st = ($urandom_range(0, 99) < 30);
            j  = ($urandom_range(0, 99) < 6);
            b  = ($urandom_range(0, 99) < 6);
            ja = 16'($urandom_range(0, 255));
            ba = 16'($urandom_range(0, 255));
            step(st, j, b, ja, ba);
            n_checks++;
            if (ifid_valid !== m_valid || ifid_instr !== m_instr || (m_valid && ifid_npc !== m_npc))
                $display("FAIL random_cyc%0d: got v=%b i=%h npc=%h want v=%b i=%h npc=%h",
                         n, ifid_valid, ifid_instr, ifid_npc, m_valid, m_instr, m_npc);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_i [3];
        logic [3:0]  exp_n [3];
        exp_i[0] = 32'h1000_000E; exp_i[1] = 32'h1000_000F; exp_i[2] = 32'h1000_0000;
        exp_n[0] = 4'd15; exp_n[1] = 4'd0; exp_n[2] = 4'd1;
        #1;
        n_checks++; if (imem_addr_w !== 4'd14) $display("FAIL wrap_reset_addr: got %h want e", imem_addr_w); else n_pass++;
        @(posedge clk); #1;
        rst_w = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (ifid_valid_w !== 1'b1 || ifid_instr_w !== exp_i[i] || ifid_npc_w !== exp_n[i])
                $display("FAIL wrap%0d: got v=%b i=%h npc=%h want 1/%h/%h", i, ifid_valid_w, ifid_instr_w,
                         ifid_npc_w, exp_i[i], exp_n[i]);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        n_checks++;
        if (ifid_valid !== m_valid || ifid_instr !== m_instr)
            $display("FAIL areset_pre: got v=%b i=%h want v=%b i=%h", ifid_valid, ifid_instr, m_valid, m_instr);
        else n_pass++;
        #3 rst = 1'b0;
        #1;
        n_checks++;
        if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_npc !== 16'h0 || imem_addr !== 16'h0)
            $display("FAIL areset_noclk: got v=%b i=%h npc=%h addr=%h want all 0", ifid_valid, ifid_instr, ifid_npc, imem_addr);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        n_checks++;
        if (ifid_valid !== 1'b1 || ifid_instr !== 32'h1000_0000 || ifid_npc !== 16'h0001)
            $display("FAIL areset_restart: got v=%b i=%h npc=%h want 1/10000000/0001", ifid_valid, ifid_instr, ifid_npc);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_jump();
        test_simultaneous();
        test_stall();
        test_redirect_stall();
        test_random();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
